pe_weight_loader: RTL and testbench

//   Write-side driver of the PE weight-load bus (w_en/addr/w) shared by a row of processing_elements.

---
 rtl/pe_weight_loader_if.sv | 11 +
 rtl/pe_weight_loader.sv | 115 +++++++++++
 tb/tb_pe_weight_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_weight_loader_if.sv
// Weight stream handshake between the AXI weight path and the PE weight loader.
interface pe_weight_loader_if #(
    parameter int WEIGHT_BW = 8
);
    logic                        valid;
    logic                        ready;
    logic signed [WEIGHT_BW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_weight_loader.sv
// Write-side driver of the PE weight-load bus: streams weights to consecutive PE addresses.
// Optional PE_WLOAD_CSUM_EN adds o_csum, the running sum of sign-extended accepted weights.
//
// state | meaning
// IDLE  | waiting for i_start, s_ready low
// LOAD  | accepting one weight per beat, writing it to the next PE address
// DRAIN | final write on the bus; o_done follows on return to IDLE
module pe_weight_loader #(
    parameter int WEIGHT_BW = 8,
    parameter int ADDR_BW   = 5,
    parameter int NUM_PE    = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [ADDR_BW:0]            i_num,
    input  logic                        i_abort,
    pe_weight_loader_if.slave           s,
    output logic                        o_w_en,
    output logic [ADDR_BW-1:0]          o_addr,
    output logic signed [WEIGHT_BW-1:0] o_w,
    output logic                        o_busy,
    output logic                        o_done
`ifdef PE_WLOAD_CSUM_EN
    ,
    output logic [WEIGHT_BW+ADDR_BW:0]  o_csum
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [ADDR_BW:0]   NUM_MAX = (ADDR_BW+1)'(NUM_PE);
    localparam logic [ADDR_BW:0]   REM_ONE = (ADDR_BW+1)'(1);
    localparam logic [ADDR_BW-1:0] BASE    = ADDR_BW'(BASE_ADDR);

    state_t             state;
    logic [ADDR_BW:0]   remain;
    logic [ADDR_BW-1:0] addr_next;
    logic [ADDR_BW:0]   num_clamp;
    logic               beat;

    always_comb begin
        num_clamp = (i_num > NUM_MAX) ? NUM_MAX : i_num;
        beat      = s.valid & s.ready;
    end

    // remain counts down the beats still owed; terminal count is 1 on the accepting beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            addr_next <= BASE;
            s.ready   <= 1'b0;
            o_w_en    <= 1'b0;
            o_addr    <= '0;
            o_w       <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef PE_WLOAD_CSUM_EN
            o_csum    <= '0;
`endif
        end else begin
            o_w_en <= 1'b0;
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        remain    <= num_clamp;
                        addr_next <= BASE;
`ifdef PE_WLOAD_CSUM_EN
                        o_csum    <= '0;
`endif
                        if (num_clamp == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s.ready <= 1'b1;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (i_abort) begin
                        state   <= IDLE;
                        s.ready <= 1'b0;
                        o_busy  <= 1'b0;
                    end else if (beat) begin
                        o_w_en    <= 1'b1;
                        o_addr    <= addr_next;
                        o_w       <= s.data;
                        addr_next <= addr_next + 1'b1;
                        remain    <= remain - 1'b1;
`ifdef PE_WLOAD_CSUM_EN
                        o_csum    <= o_csum + {{(ADDR_BW+1){s.data[WEIGHT_BW-1]}}, s.data};
`endif
                        if (remain == REM_ONE) begin
                            state   <= DRAIN;
                            s.ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= !i_abort;
                end
                default: begin
                    state   <= IDLE;
                    s.ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: transaction-level model compared every cycle, plus directed literal checks.
module tb_pe_weight_loader;
    localparam int WBW = 8;
    localparam int ABW = 5;
    localparam int NPE = 9;
    localparam int BASE_B = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic [ABW:0] i_num = '0;
    logic i_abort = 1'b0;
    logic s_valid = 1'b0;
    logic [WBW-1:0] s_data = '0;

    logic a_w_en, b_w_en, a_busy, b_busy, a_done, b_done;
    logic [ABW-1:0] a_addr, b_addr;
    logic signed [WBW-1:0] a_w, b_w;
`ifdef PE_WLOAD_CSUM_EN
    logic [WBW+ABW:0] a_csum, b_csum;
`endif

    pe_weight_loader_if #(.WEIGHT_BW(WBW)) sa ();
    pe_weight_loader_if #(.WEIGHT_BW(WBW)) sb ();
    assign sa.valid = s_valid;
    assign sa.data  = s_data;
    assign sb.valid = s_valid;
    assign sb.data  = s_data;

    pe_weight_loader #(.WEIGHT_BW(WBW), .ADDR_BW(ABW), .NUM_PE(NPE), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num(i_num), .i_abort(i_abort),
        .s(sa.slave), .o_w_en(a_w_en), .o_addr(a_addr), .o_w(a_w), .o_busy(a_busy), .o_done(a_done)
`ifdef PE_WLOAD_CSUM_EN
        , .o_csum(a_csum)
`endif
    );

    pe_weight_loader #(.WEIGHT_BW(WBW), .ADDR_BW(ABW), .NUM_PE(NPE), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num(i_num), .i_abort(i_abort),
        .s(sb.slave), .o_w_en(b_w_en), .o_addr(b_addr), .o_w(b_w), .o_busy(b_busy), .o_done(b_done)
`ifdef PE_WLOAD_CSUM_EN
        , .o_csum(b_csum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: beats still owed, one drain cycle, then done.
    int m_left = 0;
    bit m_drain = 1'b0;
    int m_cnt = 0;
    int m_sum = 0;
    bit e_w_en = 1'b0;
    bit e_done = 1'b0;
    int e_addr_a = 0;
    int e_addr_b = 0;
    int e_w = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_drain = 1'b0; m_cnt = 0; m_sum = 0;
            e_w_en = 1'b0; e_done = 1'b0; e_addr_a = 0; e_addr_b = 0; e_w = 0;
        end else begin
            e_w_en = 1'b0;
            e_done = 1'b0;
            if ((m_left > 0 || m_drain) && i_abort) begin
                m_left = 0;
                m_drain = 1'b0;
            end else if (m_drain) begin
                m_drain = 1'b0;
                e_done = 1'b1;
            end else if (m_left > 0) begin
                if (s_valid) begin
                    e_w_en = 1'b1;
                    e_addr_a = m_cnt % (1 << ABW);
                    e_addr_b = (BASE_B + m_cnt) % (1 << ABW);
                    e_w = int'(s_data);
                    m_sum += int'($signed(s_data));
                    m_cnt++;
                    m_left--;
                    if (m_left == 0) m_drain = 1'b1;
                end
            end else if (i_start && !i_abort) begin
                m_left = (int'(i_num) > NPE) ? NPE : int'(i_num);
                m_cnt = 0;
                m_sum = 0;
                if (m_left == 0) e_done = 1'b1;
            end
        end
    end

    // Write log for the directed literal checks
    int log_a[$];
    int log_b[$];
    int log_w[$];
    int log_c[$];
    int done_cnt = 0;
    int done_cyc = -1;
    bit busy_seen = 1'b0;

    always @(negedge clk) begin
        chk("ready_a", int'(sa.ready), int'(m_left > 0));
        chk("ready_b", int'(sb.ready), int'(m_left > 0));
        chk("w_en_a", int'(a_w_en), int'(e_w_en));
        chk("w_en_b", int'(b_w_en), int'(e_w_en));
        chk("addr_a", int'(a_addr), e_addr_a);
        chk("addr_b", int'(b_addr), e_addr_b);
        chk("w_a", int'(a_w) & 8'hFF, e_w);
        chk("busy_a", int'(a_busy), int'(m_left > 0 || m_drain));
        chk("done_a", int'(a_done), int'(e_done));
        chk("done_b", int'(b_done), int'(e_done));
`ifdef PE_WLOAD_CSUM_EN
        chk("csum_a", int'(a_csum), m_sum & 14'h3FFF);
        chk("csum_b", int'(b_csum), m_sum & 14'h3FFF);
`endif
        if (a_w_en) begin
            log_a.push_back(int'(a_addr));
            log_b.push_back(int'(b_addr));
            log_w.push_back(int'(a_w) & 8'hFF);
            log_c.push_back(cyc);
        end
        if (a_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (a_busy) busy_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete(); log_b.delete(); log_w.delete(); log_c.delete();
        done_cnt = 0; done_cyc = -1; busy_seen = 1'b0;
    endtask

    task automatic start_load(input int n);
        i_start = 1'b1;
        i_num = 6'(n);
        step();
        i_start = 1'b0;
    endtask

    task automatic beat(input int v, input int d);
        s_valid = v[0];
        s_data = 8'(d);
        step();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    int last_t;
    int start_c;

    initial begin
        idle(3);
        chk("reset_w_en", int'(a_w_en), 0);
        chk("reset_busy", int'(a_busy), 0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back stream of 9 weights 1..9
        clear_log();
        start_load(9);
        for (int k = 1; k <= 9; k++) beat(1, k);
        last_t = cyc - 1;
        idle(4);
        chk("b2b_count", log_a.size(), 9);
        if (log_a.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk("b2b_addr", log_a[k], k);
                chk("b2b_data", log_w[k], k + 1);
                chk("b2b_cyc", log_c[k], log_c[0] + k);
            end
        end
        chk("b2b_done_cyc", done_cyc, last_t + 2);
        chk("b2b_done_cnt", done_cnt, 1);
`ifdef PE_WLOAD_CSUM_EN
        chk("b2b_csum", int'(a_csum), 45);
`endif

        // Gapped stream 5,-3,7
        clear_log();
        start_load(3);
        beat(1, 5); beat(0, 0); beat(0, 0); beat(1, -3); beat(1, 7);
        idle(4);
        chk("gap_count", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("gap_a0", log_a[0], 0); chk("gap_w0", log_w[0], 5);
            chk("gap_a1", log_a[1], 1); chk("gap_w1", log_w[1], 8'hFD);
            chk("gap_a2", log_a[2], 2); chk("gap_w2", log_w[2], 7);
            chk("gap_spacing", log_c[1] - log_c[0], 3);
        end
        chk("gap_done_cnt", done_cnt, 1);

        // Clamp: 20 requested, 9 written
        clear_log();
        start_load(20);
        for (int k = 0; k < 14; k++) beat(1, 100 + k);
        idle(3);
        chk("clamp_count", log_a.size(), 9);
        chk("clamp_done_cnt", done_cnt, 1);

        // Zero count
        clear_log();
        start_load(0);
        start_c = cyc;
        idle(4);
        chk("zero_count", log_a.size(), 0);
        chk("zero_done_cyc", done_cyc, start_c);
        chk("zero_busy", int'(busy_seen), 0);

        // Wrap on the BASE_ADDR=30 instance
        clear_log();
        start_load(4);
        for (int k = 0; k < 4; k++) beat(1, k + 11);
        idle(3);
        chk("wrap_count", log_b.size(), 4);
        if (log_b.size() == 4) begin
            chk("wrap_a0", log_b[0], 30); chk("wrap_a1", log_b[1], 31);
            chk("wrap_a2", log_b[2], 0);  chk("wrap_a3", log_b[3], 1);
        end

        // Start and abort together: nothing starts
        clear_log();
        i_start = 1'b1; i_abort = 1'b1; i_num = 6'd5;
        step();
        idle(3);
        chk("startabort_busy", int'(busy_seen), 0);
        chk("startabort_done", done_cnt, 0);

        // Abort after 2 beats, then a 2-weight load with an ignored mid-load start
        clear_log();
        start_load(5);
        beat(1, 10); beat(1, 20);
        i_abort = 1'b1; beat(1, 99);
        i_abort = 1'b0;
        idle(3);
        chk("abort_done", done_cnt, 0);
        start_load(2);
        beat(1, 3);
        i_start = 1'b1; i_num = 6'd7; beat(1, 4);
        i_start = 1'b0;
        idle(4);
        chk("abort_count", log_a.size(), 4);
        if (log_a.size() == 4) begin
            chk("abort_a2", log_a[2], 0); chk("abort_w2", log_w[2], 3);
            chk("abort_a3", log_a[3], 1); chk("abort_w3", log_w[3], 4);
        end
        chk("abort_done_cnt", done_cnt, 1);
`ifdef PE_WLOAD_CSUM_EN
        chk("abort_csum", int'(a_csum), 7);
`endif

        // Async reset mid-load
        start_load(9);
        beat(1, 21); beat(1, 22); beat(1, 23);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_w_en", int'(a_w_en), 0);
        chk("arst_addr", int'(a_addr), 0);
        chk("arst_w", int'(a_w), 0);
        chk("arst_busy", int'(a_busy), 0);
        chk("arst_ready", int'(sa.ready), 0);
        chk("arst_done", int'(a_done), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clear_log();
        start_load(9);
        for (int k = 0; k < 9; k++) beat(1, 40 + k);
        idle(4);
        chk("post_rst_count", log_a.size(), 9);
        chk("post_rst_done", done_cnt, 1);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            i_start = ($urandom_range(0, 7) == 0);
            i_num = 6'($urandom_range(0, 20));
            i_abort = ($urandom_range(0, 39) == 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data = 8'($urandom);
            step();
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
